// File: rtl/inst_predecode_queue.sv
// Instruction queue between fetch and decode: predecodes each entry at push and runs the load-use interlock.
// Optional macro IPQ_BYPASS_EN: an empty queue forwards fetch straight to the decode head in the same cycle.
module inst_predecode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNTW  = 3
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            fe_valid,
    output logic            fe_ready,
    input  logic [XLEN-1:0] fe_pc,
    input  logic [31:0]     fe_ir,
    input  logic            fe_rv16,
    input  logic            fe_predict_taken,
    input  logic            flush,
    output logic            de_valid,
    input  logic            de_ready,
    output logic [XLEN-1:0] de_pc,
    output logic [31:0]     de_ir,
    output logic            de_rv16,
    output logic            de_predict_taken,
    output logic            de_is_load,
    output logic            de_is_store,
    output logic            de_is_branch,
    output logic            de_is_jump,
    output logic            de_is_system,
    output logic            de_is_fence,
    output logic [4:0]      de_rs1_addr,
    output logic [4:0]      de_rs2_addr,
    output logic [4:0]      de_rd_addr,
    output logic            de_r_rs1,
    output logic            de_r_rs2,
    input  logic            ex_load,
    input  logic [4:0]      ex_wr_regindex,
    output logic            de_stall,
    output logic [CNTW-1:0] count
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic is_load;
        logic is_store;
        logic is_branch;
        logic is_jump;
        logic is_system;
        logic is_fence;
        logic r_rs1;
        logic r_rs2;
    } pd_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     ir;
        logic            rv16;
        logic            pt;
        pd_t             pd;
    } entry_t;

    function automatic pd_t predecode(input logic [31:0] ir);
        pd_t pd;
        pd = '0;
        case (ir[6:0])
            7'b0000011: begin pd.is_load = 1'b1; pd.r_rs1 = 1'b1; end
            7'b0100011: begin pd.is_store = 1'b1; pd.r_rs1 = 1'b1; pd.r_rs2 = 1'b1; end
            7'b1100011: begin pd.is_branch = 1'b1; pd.r_rs1 = 1'b1; pd.r_rs2 = 1'b1; end
            7'b1101111: pd.is_jump = 1'b1;
            7'b1100111: begin pd.is_jump = 1'b1; pd.r_rs1 = 1'b1; end
            7'b1110011: begin
                pd.is_system = 1'b1;
                // Only CSRRW/CSRRS/CSRRC read a register; the immediate forms and ECALL/MRET do not.
                pd.r_rs1 = (ir[14:12] inside {3'd1, 3'd2, 3'd3});
            end
            7'b0001111: pd.is_fence = 1'b1;
            7'b0010011: pd.r_rs1 = 1'b1;
            7'b0110011: begin pd.r_rs1 = 1'b1; pd.r_rs2 = 1'b1; end
            default: ;
        endcase
        return pd;
    endfunction

    entry_t          mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0] count_q, count_d;

    entry_t fe_entry, head;
    logic   head_valid, push, pop, do_push, do_pop;

    assign fe_entry = '{pc: fe_pc, ir: fe_ir, rv16: fe_rv16, pt: fe_predict_taken,
                        pd: predecode(fe_ir)};
    assign fe_ready = (count_q != CNTW'(DEPTH));
    assign push     = fe_valid & fe_ready;
    assign pop      = head_valid & de_ready & ~de_stall;

`ifdef IPQ_BYPASS_EN
    logic bypass;
    assign bypass  = (count_q == '0) & fe_valid & ~flush;
    // A bypassed instruction consumed in the same cycle never touches storage.
    assign do_push = push & ~flush & ~(bypass & pop);
    assign do_pop  = pop & ~flush & ~bypass;
`else
    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush;
`endif

    always_comb begin
        head       = mem_q[rd_ptr_q];
        head_valid = vld_q[rd_ptr_q];
`ifdef IPQ_BYPASS_EN
        if (bypass) begin
            head       = fe_entry;
            head_valid = 1'b1;
        end
`endif
    end

    assign de_stall = head_valid & ex_load & (ex_wr_regindex != 5'd0) &
                      ((head.pd.r_rs1 & (ex_wr_regindex == head.ir[19:15])) |
                       (head.pd.r_rs2 & (ex_wr_regindex == head.ir[24:20])));

    // NOTE: every output gets a value before any condition, so no latch can be inferred.
    always_comb begin
        de_valid         = head_valid;
        de_pc            = '0;
        de_ir            = '0;
        de_rv16          = 1'b0;
        de_predict_taken = 1'b0;
        de_is_load       = 1'b0;
        de_is_store      = 1'b0;
        de_is_branch     = 1'b0;
        de_is_jump       = 1'b0;
        de_is_system     = 1'b0;
        de_is_fence      = 1'b0;
        de_rs1_addr      = '0;
        de_rs2_addr      = '0;
        de_rd_addr       = '0;
        de_r_rs1         = 1'b0;
        de_r_rs2         = 1'b0;
        if (head_valid) begin
            de_pc            = head.pc;
            de_ir            = head.ir;
            de_rv16          = head.rv16;
            de_predict_taken = head.pt;
            de_is_load       = head.pd.is_load;
            de_is_store      = head.pd.is_store;
            de_is_branch     = head.pd.is_branch;
            de_is_jump       = head.pd.is_jump;
            de_is_system     = head.pd.is_system;
            de_is_fence      = head.pd.is_fence;
            de_rs1_addr      = head.ir[19:15];
            de_rs2_addr      = head.ir[24:20];
            de_rd_addr       = head.ir[11:7];
            de_r_rs1         = head.pd.r_rs1;
            de_r_rs2         = head.pd.r_rs2;
        end
    end

    always_comb begin
        count_d = count_q + CNTW'(do_push) - CNTW'(do_pop);
    end

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                vld_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    // NOTE: payload storage is deliberately not reset; the valid bits decide whether it is visible.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= fe_entry;
    end

    assign count = count_q;
endmodule

// File: tb/tb_inst_predecode_queue.sv
// Directed self-checking bench for inst_predecode_queue (DEPTH=4); inputs change 1ns after each rising edge.
module tb_inst_predecode_queue;
    localparam int XLEN = 32;
    localparam int CNTW = 3;

    logic            clk = 1'b0;
    logic            rstn;
    logic            fe_valid, fe_ready, fe_rv16, fe_predict_taken, flush;
    logic [XLEN-1:0] fe_pc, de_pc;
    logic [31:0]     fe_ir, de_ir;
    logic            de_valid, de_ready, de_rv16, de_predict_taken;
    logic            de_is_load, de_is_store, de_is_branch, de_is_jump, de_is_system, de_is_fence;
    logic [4:0]      de_rs1_addr, de_rs2_addr, de_rd_addr, ex_wr_regindex;
    logic            de_r_rs1, de_r_rs2, ex_load, de_stall;
    logic [CNTW-1:0] count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_predecode_queue #(.XLEN(XLEN), .DEPTH(4), .CNTW(CNTW)) dut (
        .clk(clk), .rstn(rstn),
        .fe_valid(fe_valid), .fe_ready(fe_ready), .fe_pc(fe_pc), .fe_ir(fe_ir),
        .fe_rv16(fe_rv16), .fe_predict_taken(fe_predict_taken), .flush(flush),
        .de_valid(de_valid), .de_ready(de_ready), .de_pc(de_pc), .de_ir(de_ir),
        .de_rv16(de_rv16), .de_predict_taken(de_predict_taken),
        .de_is_load(de_is_load), .de_is_store(de_is_store), .de_is_branch(de_is_branch),
        .de_is_jump(de_is_jump), .de_is_system(de_is_system), .de_is_fence(de_is_fence),
        .de_rs1_addr(de_rs1_addr), .de_rs2_addr(de_rs2_addr), .de_rd_addr(de_rd_addr),
        .de_r_rs1(de_r_rs1), .de_r_rs2(de_r_rs2),
        .ex_load(ex_load), .ex_wr_regindex(ex_wr_regindex),
        .de_stall(de_stall), .count(count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rstn = 1'b0; fe_valid = 1'b0; fe_pc = '0; fe_ir = '0; fe_rv16 = 1'b0;
        fe_predict_taken = 1'b0; flush = 1'b0; de_ready = 1'b0;
        ex_load = 1'b0; ex_wr_regindex = '0;
        tick(); tick();
        check("rst_de_valid", de_valid, 0);
        check("rst_fe_ready", fe_ready, 1);
        check("rst_count", count, 0);
        check("rst_de_stall", de_stall, 0);
        check("rst_de_pc", de_pc, 0);
        check("rst_de_ir", de_ir, 0);
        rstn = 1'b1;
        tick();

        // Fill all four entries while decode is stalled.
        fe_valid = 1'b1; fe_ir = 32'h0000_0013;
        for (int i = 0; i < 4; i++) begin
            fe_pc = 32'h100 + 32'(4 * i);
            fe_rv16 = (i == 1); fe_predict_taken = (i == 2);
            tick();
        end
        fe_pc = 32'h110; fe_rv16 = 1'b0; fe_predict_taken = 1'b0;
        settle();
        check("full_count", count, 4);
        check("full_fe_ready", fe_ready, 0);
        check("full_head_pc", de_pc, 32'h100);
        tick();
        fe_valid = 1'b0;
        settle();
        check("refused_count", count, 4);

        de_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("drain_valid", de_valid, 1);
            check("drain_pc", de_pc, 32'h100 + 32'(4 * i));
            check("drain_rv16", de_rv16, (i == 1));
            check("drain_pt", de_predict_taken, (i == 2));
            tick();
        end
        de_ready = 1'b0;
        settle();
        check("drained_valid", de_valid, 0);
        check("drained_count", count, 0);
        check("drained_pc_zero", de_pc, 0);

        // Load-use: LW x5,0(x1) then ADD x6,x5,x7.
        fe_valid = 1'b1; fe_pc = 32'h200; fe_ir = 32'h0000_A283;
        tick();
        fe_pc = 32'h204; fe_ir = 32'h0072_8333;
        tick();
        fe_valid = 1'b0;
        settle();
        check("lw_is_load", de_is_load, 1);
        check("lw_rd", de_rd_addr, 5);
        check("lw_r_rs2", de_r_rs2, 0);
        de_ready = 1'b1;
        tick();
        ex_load = 1'b1; ex_wr_regindex = 5'd5;
        settle();
        check("add_pc", de_pc, 32'h204);
        check("add_stall", de_stall, 1);
        check("add_rs1", de_rs1_addr, 5);
        check("add_rs2", de_rs2_addr, 7);
        check("add_rd", de_rd_addr, 6);
        check("add_r_rs2", de_r_rs2, 1);
        tick();
        check("stall_count", count, 1);
        check("stall_head", de_pc, 32'h204);
        ex_load = 1'b0;
        settle();
        check("unstall", de_stall, 0);
        tick();
        check("unstall_pop_count", count, 0);
        check("unstall_pop_valid", de_valid, 0);

        // ADDI x3,x0,1 against a load writing x0: never stalls.
        de_ready = 1'b0;
        fe_valid = 1'b1; fe_pc = 32'h300; fe_ir = 32'h0010_0193;
        tick();
        fe_valid = 1'b0;
        ex_load = 1'b1; ex_wr_regindex = 5'd0; de_ready = 1'b1;
        settle();
        check("x0_r_rs1", de_r_rs1, 1);
        check("x0_rs1", de_rs1_addr, 0);
        check("x0_stall", de_stall, 0);
        tick();
        check("x0_pop_count", count, 0);
        ex_load = 1'b0; de_ready = 1'b0;

        // Streaming at count=2: pointers wrap while order holds.
        fe_valid = 1'b1;
        fe_ir = 32'h0000_0013;
        fe_pc = 32'h400; tick();
        fe_pc = 32'h404; tick();
        de_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            fe_pc = 32'h408 + 32'(4 * i);
            settle();
            check("stream_pc", de_pc, 32'h400 + 32'(4 * i));
            tick();
            check("stream_count", count, 2);
        end
        de_ready = 1'b0;
        fe_pc = 32'h430;
        tick();
        check("pre_flush_count", count, 3);

        // Flush with a simultaneous push drops everything.
        flush = 1'b1; fe_pc = 32'h500;
        tick();
        flush = 1'b0; fe_valid = 1'b0;
        settle();
        check("flush_count", count, 0);
        check("flush_valid", de_valid, 0);
        tick();
        check("flush_dropped_valid", de_valid, 0);
        check("flush_dropped_count", count, 0);

        // BEQ x1,x2 predecode and first-cycle visibility.
        fe_valid = 1'b1; fe_pc = 32'h600; fe_ir = 32'h0020_8463;
        settle();
`ifdef IPQ_BYPASS_EN
        check("beq_same_cycle_valid", de_valid, 1);
`else
        check("beq_same_cycle_valid", de_valid, 0);
`endif
        tick();
        fe_valid = 1'b0;
        settle();
        check("beq_valid", de_valid, 1);
        check("beq_pc", de_pc, 32'h600);
        check("beq_is_branch", de_is_branch, 1);
        check("beq_is_load", de_is_load, 0);
        check("beq_r_rs1", de_r_rs1, 1);
        check("beq_r_rs2", de_r_rs2, 1);
        check("beq_rs1", de_rs1_addr, 1);
        check("beq_rs2", de_rs2_addr, 2);

        // Asynchronous reset while holding an entry.
        rstn = 1'b0;
        settle();
        check("async_rst_count", count, 0);
        check("async_rst_valid", de_valid, 0);
        check("async_rst_ready", fe_ready, 1);
        rstn = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
